rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between two producers.
- Producer 1 is the pipeline writeback stage. It cannot be back-pressured except by an explicit stall.
- Producer 2 is a multi-cycle unit (mult/div). It uses a valid/ready handshake into a 1-entry hold buffer.
- Writeback has priority. A starvation counter forces a one-cycle pipeline stall so the held write eventually retires. Outputs drive the register file write port directly.

---
 rtl/rf_arb_pkg.sv | 15 +
 rtl/rf_arb_hold_buf.sv | 35 +++
 rtl/rf_write_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write arbiter.
// FSM encodings, default widths and the starvation counter width.
package rf_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_HELD  = 2'd1;
    localparam arb_state_t ST_FORCE = 2'd2;

endpackage

// File: rtl/rf_arb_hold_buf.sv
// One-entry holding register for a multi-cycle result awaiting the write port.
// Load takes precedence; drain and kill both empty the entry.
module rf_arb_hold_buf
    import rf_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              drain,
    input  logic              kill,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= ld_addr;
            data  <= ld_data;
        end else if (drain || kill) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and a multi-cycle unit.
// Optional macro RF_ARB_PERF_EN adds forced-stall and same-address-kill counters.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              mc_valid_i,
    output logic              mc_ready_o,
    input  logic [ADDR_W-1:0] mc_addr_i,
    input  logic [DATA_W-1:0] mc_data_i,
    output logic              stall_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic              err_o
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_kill_cnt_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_MAX - 1);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              load;
    logic              drain;
    logic              kill_hit;
    logic              wb_nz;
    logic              buf_nz;

    rf_arb_hold_buf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hold_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (load),
        .drain   (drain),
        .kill    (kill_hit),
        .ld_addr (mc_addr_i),
        .ld_data (mc_data_i),
        .valid   (buf_valid),
        .addr    (buf_addr),
        .data    (buf_data)
    );

    assign mc_ready_o = (state == ST_IDLE);
    assign wb_nz      = wb_we_i && (wb_addr_i != '0);
    assign buf_nz     = (buf_addr != '0);
    assign load       = (state == ST_IDLE) && mc_valid_i;
    assign drain      = (state == ST_FORCE) || ((state == ST_HELD) && !wb_we_i);
    // A younger writeback to the same register makes the held result obsolete.
    assign kill_hit   = (state == ST_HELD) && wb_we_i && buf_nz && (wb_addr_i == buf_addr);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (mc_valid_i) state_nx = ST_HELD;
            ST_HELD: begin
                if (!wb_we_i || kill_hit)  state_nx = ST_IDLE;
                else if (cnt >= CNT_LIMIT) state_nx = ST_FORCE;
            end
            ST_FORCE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stall_o   <= 1'b0;
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
            err_o     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= ((state == ST_HELD) && (state_nx == ST_HELD)) ? cnt + 1'b1 : '0;
            stall_o <= (state_nx == ST_FORCE);
            err_o   <= err_o || ((state == ST_FORCE) && wb_we_i);
            if (drain) begin
                rf_we_o   <= buf_valid && buf_nz;
                rf_addr_o <= buf_addr;
                rf_data_o <= buf_data;
            end else begin
                rf_we_o   <= wb_nz;
                rf_addr_o <= wb_addr_i;
                rf_data_o <= wb_data_i;
            end
        end
    end

`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_stall_cnt_o <= '0;
            perf_kill_cnt_o  <= '0;
        end else begin
            if ((state == ST_HELD) && (state_nx == ST_FORCE)) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (kill_hit)                                      perf_kill_cnt_o  <= perf_kill_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a cycle-level reference model.
// Build with RF_ARB_PERF_EN defined to also check the performance counters.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 4;

    logic          clk_i      = 1'b0;
    logic          rst_i      = 1'b0;
    logic          wb_we_i    = 1'b0;
    logic [AW-1:0] wb_addr_i  = '0;
    logic [DW-1:0] wb_data_i  = '0;
    logic          mc_valid_i = 1'b0;
    logic [AW-1:0] mc_addr_i  = '0;
    logic [DW-1:0] mc_data_i  = '0;
    logic          mc_ready_o;
    logic          stall_o;
    logic          rf_we_o;
    logic [AW-1:0] rf_addr_o;
    logic [DW-1:0] rf_data_o;
    logic          err_o;
`ifdef RF_ARB_PERF_EN
    logic [31:0]   perf_stall_cnt_o;
    logic [31:0]   perf_kill_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: what the write port must show, derived from arbitration rules
    bit            m_held    = 1'b0;
    bit            m_force   = 1'b0;
    bit            m_err     = 1'b0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_data    = '0;
    int            m_starved = 0;
    int            m_kills   = 0;
    int            m_stalls  = 0;
    bit            e_we      = 1'b0;
    logic [AW-1:0] e_addr    = '0;
    logic [DW-1:0] e_data    = '0;

    rf_write_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (SM)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .mc_valid_i (mc_valid_i),
        .mc_ready_o (mc_ready_o),
        .mc_addr_i  (mc_addr_i),
        .mc_data_i  (mc_data_i),
        .stall_o    (stall_o),
        .rf_we_o    (rf_we_o),
        .rf_addr_o  (rf_addr_o),
        .rf_data_o  (rf_data_o),
        .err_o      (err_o)
`ifdef RF_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_kill_cnt_o  (perf_kill_cnt_o)
`else
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        wb_we_i    = we;
        wb_addr_i  = wa;
        wb_data_i  = wd;
        mc_valid_i = mv;
        mc_addr_i  = ma;
        mc_data_i  = md;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkWrite(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
        checkOutput({name, "_we"}, 32'(rf_we_o), 32'd1);
        checkOutput({name, "_addr"}, 32'(rf_addr_o), 32'(a));
        checkOutput({name, "_data"}, rf_data_o, d);
    endtask

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_held    = 1'b0;
            m_force   = 1'b0;
            m_err     = 1'b0;
            m_starved = 0;
            m_kills   = 0;
            m_stalls  = 0;
            e_we      = 1'b0;
        end else begin
            e_we = 1'b0;
            if (m_force || (m_held && !wb_we_i)) begin
                e_we   = (m_addr != 0);
                e_addr = m_addr;
                e_data = m_data;
                if (m_force && wb_we_i) m_err = 1'b1;
                m_held    = 1'b0;
                m_force   = 1'b0;
                m_starved = 0;
            end else begin
                e_we   = wb_we_i && (wb_addr_i != 0);
                e_addr = wb_addr_i;
                e_data = wb_data_i;
                if (m_held) begin
                    if (wb_addr_i == m_addr && m_addr != 0) begin
                        m_held    = 1'b0;
                        m_starved = 0;
                        m_kills++;
                    end else begin
                        m_starved++;
                        if (m_starved == SM) begin
                            m_force = 1'b1;
                            m_stalls++;
                        end
                    end
                end else if (mc_valid_i) begin
                    m_held = 1'b1;
                    m_addr = mc_addr_i;
                    m_data = mc_data_i;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        checkOutput("model_rf_we", 32'(rf_we_o), 32'(e_we));
        checkOutput("model_mc_ready", 32'(mc_ready_o), 32'(!m_held));
        checkOutput("model_stall", 32'(stall_o), 32'(m_force));
        checkOutput("model_err", 32'(err_o), 32'(m_err));
        if (e_we) begin
            checkOutput("model_rf_addr", 32'(rf_addr_o), 32'(e_addr));
            checkOutput("model_rf_data", rf_data_o, e_data);
        end
    end

    initial begin
        #1;
        checkOutput("rst_rf_we", 32'(rf_we_o), 32'd0);
        checkOutput("rst_rf_addr", 32'(rf_addr_o), 32'd0);
        checkOutput("rst_rf_data", rf_data_o, 32'd0);
        checkOutput("rst_mc_ready", 32'(mc_ready_o), 32'd1);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        applyStimulus(1, 5'd3, 32'hAA, 0, '0, '0);
        checkWrite("wb_only", 5'd3, 32'hAA);

        applyStimulus(0, '0, '0, 1, 5'd7, 32'h1234);
        checkOutput("idle_cap_we", 32'(rf_we_o), 32'd0);
        checkOutput("idle_cap_ready", 32'(mc_ready_o), 32'd0);
        applyStimulus(0, '0, '0, 0, '0, '0);
        checkWrite("idle_drain", 5'd7, 32'h1234);
        checkOutput("idle_drain_ready", 32'(mc_ready_o), 32'd1);

        applyStimulus(1, 5'd1, 32'h11, 1, 5'd5, 32'h77);
        checkOutput("starve_cap_ready", 32'(mc_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'(i + 2), 32'(i + 'h20), 0, '0, '0);
            checkOutput("starve_no_stall", 32'(stall_o), 32'd0);
        end
        applyStimulus(1, 5'd6, 32'h66, 0, '0, '0);
        checkOutput("starve_stall", 32'(stall_o), 32'd1);
        checkWrite("starve_last_wb", 5'd6, 32'h66);
        applyStimulus(1, 5'd8, 32'h88, 0, '0, '0);
        checkWrite("force_drain", 5'd5, 32'h77);
        checkOutput("force_err", 32'(err_o), 32'd1);
        checkOutput("force_stall_clr", 32'(stall_o), 32'd0);
        applyStimulus(0, '0, '0, 0, '0, '0);
        checkOutput("err_sticky", 32'(err_o), 32'd1);
        checkOutput("after_force_we", 32'(rf_we_o), 32'd0);

        applyStimulus(0, '0, '0, 1, 5'd9, 32'hDEAD);
        applyStimulus(1, 5'd9, 32'h55, 0, '0, '0);
        checkWrite("kill_wb", 5'd9, 32'h55);
        checkOutput("kill_ready", 32'(mc_ready_o), 32'd1);
        applyStimulus(0, '0, '0, 0, '0, '0);
        checkOutput("kill_no_stale", 32'(rf_we_o), 32'd0);

        applyStimulus(1, 5'd0, 32'h12, 1, 5'd0, 32'hBEEF);
        checkOutput("a0_wb_we", 32'(rf_we_o), 32'd0);
        checkOutput("a0_cap_ready", 32'(mc_ready_o), 32'd0);
        applyStimulus(0, '0, '0, 0, '0, '0);
        checkOutput("a0_drain_we", 32'(rf_we_o), 32'd0);
        checkOutput("a0_ready", 32'(mc_ready_o), 32'd1);

`ifdef RF_ARB_PERF_EN
        checkOutput("perf_stall", perf_stall_cnt_o, 32'd1);
        checkOutput("perf_kill", perf_kill_cnt_o, 32'd1);
`else
        checkOutput("model_kill_count", 32'(m_kills), 32'd1);
`endif

        applyStimulus(1, 5'd4, 32'h44, 1, 5'd10, 32'hCAFE);
        checkWrite("pre_rst_wb", 5'd4, 32'h44);
        checkOutput("pre_rst_ready", 32'(mc_ready_o), 32'd0);
        #2 rst_i = 1'b0;
        #1;
        checkOutput("mid_rst_we", 32'(rf_we_o), 32'd0);
        checkOutput("mid_rst_ready", 32'(mc_ready_o), 32'd1);
        checkOutput("mid_rst_stall", 32'(stall_o), 32'd0);
        checkOutput("mid_rst_err", 32'(err_o), 32'd0);
        wb_we_i    = 1'b0;
        mc_valid_i = 1'b0;
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, '0, '0, 0, '0, '0);
            checkOutput("post_rst_no_stale", 32'(rf_we_o), 32'd0);
            checkOutput("post_rst_ready", 32'(mc_ready_o), 32'd1);
        end

        repeat (2) @(posedge clk_i);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
